button_debouncer: RTL and testbench

Conditions a raw, asynchronous push-button or switch input into a clean, glitch-free level. It also produces single-cycle rise, fall and long-press event pulses in the system clock domain. It sits directly upstream of the clock-divided `simple_SystemVerilog` stage, and `btn_level` drives that block's `a_in`. The block has one clock domain and no handshake toward the consumer; its outputs are registered levels and pulses.

---
 rtl/button_debouncer.sv | 165 ++++++++++++++++
 tb/tb_button_debouncer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
//
// Turns a raw, bouncing, asynchronous push-button input into a clean level in
// the clk domain, plus single-cycle rise / fall / long-press event pulses.
// The debounced level is meant to drive the a_in input of the downstream
// clock-divided stage.
//
// Parameters
//   SYNC_STAGES        synchronizer depth (>= 2)
//   DEBOUNCE_CYCLES    consecutive stable synchronized samples needed to
//                      accept a level change (>= 1)
//   LONG_PRESS_CYCLES  cycles after the btn_rise cycle before long_press
//                      fires (>= 1)
//
// Ports
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   btn_in      in   raw button input, asynchronous, may bounce
//   btn_level   out  debounced level (registered)
//   btn_rise    out  one-cycle pulse when btn_level goes 0->1
//   btn_fall    out  one-cycle pulse when btn_level goes 1->0
//   long_press  out  one-cycle pulse, at most once per press
// ---------------------------------------------------------------------------
module button_debouncer #(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 1000,
  parameter int LONG_PRESS_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic long_press
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(LONG_PRESS_CYCLES + 1);

  // The sample that moves the FSM out of IDLE/PRESSED is itself the first
  // stable sample, so a wait state has seen (count + 2) samples when its
  // counter equals DB_LAST. DEBOUNCE_CYCLES == 1 skips the wait states.
  localparam int DB_TARGET = (DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0;
  localparam logic [DW-1:0] DB_LAST = DB_TARGET[DW-1:0];
  localparam int LP_TARGET = LONG_PRESS_CYCLES - 1;
  localparam logic [LW-1:0] LP_LAST = LP_TARGET[LW-1:0];
  localparam int LP_SAT_INT = LONG_PRESS_CYCLES;
  localparam logic [LW-1:0] LP_SAT = LP_SAT_INT[LW-1:0];
  localparam bit DB_SINGLE = (DEBOUNCE_CYCLES == 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [DW-1:0]          db_cnt_q, db_cnt_d;
  logic [LW-1:0]          lp_cnt_q, lp_cnt_d;
  logic                   fired_q, fired_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   long_q, long_d;
  logic                   sync;
  logic                   held;

  assign sync = sync_q[SYNC_STAGES-1];
  assign held = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

  // Synchronizer chain: the only place btn_in is sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
    end
  end

  // State register plus all counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      db_cnt_q <= '0;
      lp_cnt_q <= '0;
      fired_q  <= 1'b0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
      lp_cnt_q <= lp_cnt_d;
      fired_q  <= fired_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      long_q   <= long_d;
    end
  end

  // Next-state logic. Wait states fall back on any contrary sample and
  // commit once enough consecutive agreeing samples have been seen.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (sync) state_d = DB_SINGLE ? PRESSED : PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!sync)                   state_d = IDLE;
        else if (db_cnt_q == DB_LAST) state_d = PRESSED;
      end
      PRESSED: begin
        if (!sync) state_d = DB_SINGLE ? IDLE : RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (sync)                    state_d = PRESSED;
        else if (db_cnt_q == DB_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath logic. Pulses are derived from the transition being
  // taken so they land in the same cycle the level changes. The long-press
  // counter runs in both held states so release glitches do not restart it.
  always_comb begin
    db_cnt_d = '0;
    lp_cnt_d = lp_cnt_q;
    fired_d  = fired_q;
    long_d   = 1'b0;
    level_d  = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    rise_d   = !held && (state_d == PRESSED);
    fall_d   = held && (state_d == IDLE);

    if ((state_d == state_q) &&
        ((state_q == PRESS_WAIT) || (state_q == RELEASE_WAIT))) begin
      db_cnt_d = db_cnt_q + 1'b1;
    end

    if (rise_d) begin
      lp_cnt_d = '0;
    end else if (held) begin
      if (!fired_q && (lp_cnt_q == LP_LAST)) begin
        long_d  = 1'b1;
        fired_d = 1'b1;
      end
      if (lp_cnt_q != LP_SAT) lp_cnt_d = lp_cnt_q + 1'b1;
    end

    if (fall_d) fired_d = 1'b0;
  end

  assign btn_level  = level_q;
  assign btn_rise   = rise_q;
  assign btn_fall   = fall_q;
  assign long_press = long_q;

endmodule

// File: tb/tb_button_debouncer.sv
// ---------------------------------------------------------------------------
// tb_button_debouncer
//
// Directed bench for button_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// LONG_PRESS_CYCLES=10. Cycle k means "just after the k-th rising edge since
// the scenario started"; the input value for cycle k is driven before edge k.
// Outputs are compared as the vector {level, rise, fall, long}.
// ---------------------------------------------------------------------------
module tb_button_debouncer;

  logic clk;
  logic rst;
  logic btnIn;
  logic btnLevel;
  logic btnRise;
  logic btnFall;
  logic longPress;

  int total;
  int bad;

  button_debouncer #(
    .SYNC_STAGES      (2),
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btnIn),
    .btn_level (btnLevel),
    .btn_rise  (btnRise),
    .btn_fall  (btnFall),
    .long_press(longPress)
  );

  // 10 ns clock; inputs change on the falling edge, outputs are read 1 ns
  // after the rising edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one input value and advance to just after the next rising edge.
  task automatic applyStimulus(input logic b);
    @(negedge clk);
    btnIn = b;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset mid-cycle with the button idle; everything stays low.
  task automatic test_reset();
    logic [3:0] obs;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    obs = {btnLevel, btnRise, btnFall, longPress};
    total++;
    if (obs !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL reset_async: got %b want 0000", obs);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b0);
      obs = {btnLevel, btnRise, btnFall, longPress};
      total++;
      if (obs !== 4'b0000) begin
        bad++;
        $display("[TB] FAIL reset_hold cycle %0d: got %b want 0000", k, obs);
      end
    end
  endtask

  // Held 8 cycles: rise at 6, fall at 14, no long press.
  task automatic test_clean_press();
    logic [3:0] obs, exp;
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(k <= 8);
      exp = {(k >= 6 && k < 14), (k == 6), (k == 14), 1'b0};
      obs = {btnLevel, btnRise, btnFall, longPress};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("[TB] FAIL clean_press cycle %0d: got %b want %b", k, obs, exp);
      end
    end
  endtask

  // 1,0,1,1,0,1 then held through index 13: last 0->1 at index 5 so the
  // rise lands at 11; release from index 14 gives the fall at 20.
  task automatic test_bounce();
    logic [3:0] obs, exp;
    logic [5:0] pat;
    logic b;
    pat = 6'b101101;
    for (int k = 1; k <= 26; k++) begin
      if (k - 1 < 6) b = pat[5 - (k - 1)];
      else           b = (k - 1 < 14);
      applyStimulus(b);
      exp = {(k >= 11 && k < 20), (k == 11), (k == 20), 1'b0};
      obs = {btnLevel, btnRise, btnFall, longPress};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("[TB] FAIL bounce cycle %0d: got %b want %b", k, obs, exp);
      end
    end
  endtask

  // Held 30 cycles with a 2-cycle dropout at indices 10,11: the dropout is
  // rejected, long press fires once at 16, real release falls at 36.
  task automatic test_long_press();
    logic [3:0] obs, exp;
    for (int k = 1; k <= 42; k++) begin
      applyStimulus((k - 1 < 30) && (k - 1 != 10) && (k - 1 != 11));
      exp = {(k >= 6 && k < 36), (k == 6), (k == 36), (k == 16)};
      obs = {btnLevel, btnRise, btnFall, longPress};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("[TB] FAIL long_press cycle %0d: got %b want %b", k, obs, exp);
      end
    end
  endtask

  // Reset while pressed drops the level with no fall; the still-held button
  // is then seen as a fresh press.
  task automatic test_reset_mid_press();
    logic [3:0] obs, exp;
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1'b1);
      exp = {(k >= 6), (k == 6), 1'b0, 1'b0};
      obs = {btnLevel, btnRise, btnFall, longPress};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("[TB] FAIL pre_reset cycle %0d: got %b want %b", k, obs, exp);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    obs = {btnLevel, btnRise, btnFall, longPress};
    total++;
    if (obs !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL mid_press_reset: got %b want 0000", obs);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k <= 8) begin
        @(posedge clk);
        #1;
      end else begin
        applyStimulus(1'b0);
      end
      exp = {(k >= 6 && k < 14), (k == 6), (k == 14), 1'b0};
      obs = {btnLevel, btnRise, btnFall, longPress};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("[TB] FAIL post_reset cycle %0d: got %b want %b", k, obs, exp);
      end
    end
  endtask

  // Three 5-cycle presses separated by 5 idle cycles: pulses at 6/11,
  // 16/21, 26/31, each exactly one cycle wide.
  task automatic test_back_to_back();
    logic [3:0] obs, exp;
    int rises, falls, p;
    rises = 0;
    falls = 0;
    for (int k = 1; k <= 36; k++) begin
      p = k - 1;
      applyStimulus((p < 30) && ((p % 10) < 5));
      exp = {((k >= 6 && k < 11) || (k >= 16 && k < 21) || (k >= 26 && k < 31)),
             (k == 6 || k == 16 || k == 26),
             (k == 11 || k == 21 || k == 31),
             1'b0};
      obs = {btnLevel, btnRise, btnFall, longPress};
      if (btnRise === 1'b1) rises++;
      if (btnFall === 1'b1) falls++;
      total++;
      if (obs !== exp) begin
        bad++;
        $display("[TB] FAIL back_to_back cycle %0d: got %b want %b", k, obs, exp);
      end
    end
    total++;
    if (rises != 3) begin
      bad++;
      $display("[TB] FAIL rise_count: got %0d want 3", rises);
    end
    total++;
    if (falls != 3) begin
      bad++;
      $display("[TB] FAIL fall_count: got %0d want 3", falls);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    btnIn = 1'b0;
    $display("[TB] starting button_debouncer bench");
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_reset_mid_press();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
